// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divider.
interface div_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [3:0]      div_op;
    logic            unsigned_flag;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            ready;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    modport master (
        output start, div_op, unsigned_flag, rd_in, a, b, flush,
        input  ready, busy, valid, result, rd_out
    );
    modport slave (
        input  start, div_op, unsigned_flag, rd_in, a, b, flush,
        output ready, busy, valid, result, rd_out
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative RV32M restoring divider, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module div_unit #(parameter int XLEN = 32) (
    input logic       clk,
    input logic       reset_n,
    div_unit_if.slave bus
);
    localparam logic [3:0] DIV_DIV = 4'd1;
    localparam logic [3:0] DIV_REM = 4'd2;
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
    logic [4:0]      rd_q, rd_out_q;
    logic            is_rem_q, qneg_q, rneg_q, ready_q, busy_q, valid_q;
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] rem_d, quo_d, abs_a, abs_b, q_fix, r_fix, early;
    logic            sgn, is_rem, by_zero, ovf, accept;
    always_comb begin
        sgn = !bus.unsigned_flag;
        is_rem = bus.div_op == DIV_REM;
        abs_a = (sgn && bus.a[XLEN-1]) ? -bus.a : bus.a;
        abs_b = (sgn && bus.b[XLEN-1]) ? -bus.b : bus.b;
        by_zero = bus.b == '0;
        ovf = sgn && bus.a == MIN && bus.b == '1;
        accept = bus.start && ready_q && !bus.flush && (bus.div_op == DIV_DIV || is_rem);
        early = by_zero ? (is_rem ? bus.a : '1) : (is_rem ? '0 : MIN);
        rem_sh = {rem_q, quo_q[XLEN-1]};
        trial = rem_sh - {1'b0, dvs_q};
        rem_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
        q_fix = qneg_q ? -quo_d : quo_d;
        r_fix = rneg_q ? -rem_d : rem_d;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    is_rem_q <= is_rem;
                    qneg_q   <= sgn && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                    rneg_q   <= sgn && bus.a[XLEN-1];
                    rd_q     <= bus.rd_in;
                    rem_q    <= '0;
                    quo_q    <= abs_a;
                    dvs_q    <= abs_b;
                    cnt_q    <= '0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b1;
                    if (by_zero || ovf) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= early;
                        rd_out_q <= bus.rd_in;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= is_rem_q ? r_fix : q_fix;
                        rd_out_q <= rd_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed plan plus random operations against an arithmetic reference.
module tb_div_unit;
    localparam logic [3:0] DIV_DIV = 4'd1;
    localparam logic [3:0] DIV_REM = 4'd2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_exp = '0;
    div_unit_if dif ();
    div_unit dut (.clk(clk), .reset_n(reset_n), .bus(dif.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ref_res(input logic rem, input logic uns,
                                            input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (uns) return rem ? a % b : a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
        return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    endfunction
    task automatic present(input logic [3:0] op, input logic uns, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
        dif.div_op = op;
        dif.unsigned_flag = uns;
        dif.rd_in = rd;
        dif.a = a;
        dif.b = b;
        dif.start = 1'b1;
    endtask
    // Called #1 after an edge; accepts, waits for valid and checks everything it shows.
    task automatic do_op(input logic [3:0] op, input logic uns, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic hold);
        logic [31:0] exp;
        int exp_lat, lat, bsy;
        exp = ref_res(op == DIV_REM, uns, a, b);
        exp_lat = (b == 0 || (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        chk("ready_before", 32'(dif.ready), 32'd1);
        present(op, uns, rd, a, b);
        @(posedge clk); #1;
        if (!hold) dif.start = 1'b0;
        else dif.a = a + 32'd17;
        bsy = 0;
        for (lat = 1; lat <= 40; lat++) begin
            bsy += int'(dif.busy);
            if (dif.valid) break;
            @(posedge clk); #1;
        end
        dif.start = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(bsy), 32'(exp_lat));
        chk("result", dif.result, exp);
        chk("rd_out", 32'(dif.rd_out), 32'(rd));
        @(posedge clk); #1;
        chk("valid_drop", 32'(dif.valid), 32'd0);
        chk("ready_after", 32'(dif.ready), 32'd1);
        chk("result_hold", dif.result, exp);
        last_exp = exp;
    endtask
    initial begin
        dif.start = 1'b0;
        dif.flush = 1'b0;
        dif.div_op = DIV_DIV;
        dif.unsigned_flag = 1'b0;
        dif.rd_in = '0;
        dif.a = '0;
        dif.b = '0;
        #12;
        chk("rst_ready", 32'(dif.ready), 32'd1);
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_valid", 32'(dif.valid), 32'd0);
        chk("rst_result", dif.result, 32'd0);
        chk("rst_rd", 32'(dif.rd_out), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_op(DIV_DIV, 1'b0, 5'd5, 32'd100, 32'd7, 1'b0);
        do_op(DIV_REM, 1'b0, 5'd6, 32'hFFFF_FF9C, 32'd7, 1'b0);
        do_op(DIV_DIV, 1'b0, 5'd7, 32'hFFFF_FF9C, 32'd7, 1'b0);
        do_op(DIV_REM, 1'b0, 5'd8, 32'd100, 32'hFFFF_FFF9, 1'b0);
        do_op(DIV_DIV, 1'b1, 5'd9, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(DIV_REM, 1'b1, 5'd10, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(DIV_DIV, 1'b0, 5'd11, 32'd55, 32'd0, 1'b0);
        do_op(DIV_REM, 1'b0, 5'd12, 32'd1234, 32'd0, 1'b0);
        do_op(DIV_DIV, 1'b0, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(DIV_REM, 1'b0, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(DIV_DIV, 1'b1, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        // start held through CALC with a changed operand: must not re-latch or re-accept
        do_op(DIV_DIV, 1'b0, 5'd16, 32'd100, 32'd7, 1'b1);
        present(4'd7, 1'b0, 5'd1, 32'd10, 32'd2);
        @(posedge clk); #1;
        dif.start = 1'b0;
        chk("bad_op_ready", 32'(dif.ready), 32'd1);
        chk("bad_op_busy", 32'(dif.busy), 32'd0);
        present(DIV_DIV, 1'b0, 5'd1, 32'd10, 32'd2);
        dif.flush = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        dif.flush = 1'b0;
        chk("flush_start_ready", 32'(dif.ready), 32'd1);
        chk("flush_start_busy", 32'(dif.busy), 32'd0);
        present(DIV_DIV, 1'b0, 5'd2, 32'd1000, 32'd3);
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 dif.flush = 1'b1;
        @(posedge clk); #1;
        dif.flush = 1'b0;
        chk("flush_valid", 32'(dif.valid), 32'd0);
        chk("flush_ready", 32'(dif.ready), 32'd1);
        chk("flush_busy", 32'(dif.busy), 32'd0);
        chk("flush_result", dif.result, last_exp);
        begin
            int seen = 0;
            repeat (30) begin
                @(posedge clk); #1;
                seen += int'(dif.valid);
            end
            chk("flush_no_valid", 32'(seen), 32'd0);
        end
        do_op(DIV_REM, 1'b0, 5'd3, 32'd1000, 32'd3, 1'b0);
        present(DIV_DIV, 1'b0, 5'd4, 32'd77, 32'd5);
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(dif.ready), 32'd1);
        chk("arst_busy", 32'(dif.busy), 32'd0);
        chk("arst_valid", 32'(dif.valid), 32'd0);
        chk("arst_result", dif.result, 32'd0);
        chk("arst_rd", 32'(dif.rd_out), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_op(DIV_DIV, 1'b0, 5'd20, 32'd9, 32'd3, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            int kind;
            ra = $urandom;
            rb = $urandom;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) rb = 32'd0;
            else if (kind == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (kind < 5) rb = 32'($urandom_range(1, 300)) * (kind == 4 ? -32'sd1 : 32'sd1);
            do_op($urandom_range(0, 1) ? DIV_REM : DIV_DIV, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), ra, rb, 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
